// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith, bit-serial SLL/SRL behind a
// start/busy/done handshake. Result and flags are registered and only move on completion.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      ALU_control,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] ALU_result,
  output logic            Zero,
  output logic            Overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [XLEN-1:0]     acc;
  logic [SHAMT_W-1:0]  cnt;
  logic                shl;

  logic [SHAMT_W-1:0]  shamt;
  logic                is_shift;
  logic [XLEN-1:0]     sum, diff, f_res, acc_nx;
  logic                f_ovf;

  assign shamt    = SrcB[SHAMT_W-1:0];
  assign is_shift = (ALU_control == OP_SLL) || (ALU_control == OP_SRL);
  assign acc_nx   = shl ? {acc[XLEN-2:0], 1'b0} : {1'b0, acc[XLEN-1:1]};

  // Single-cycle datapath; shifts here only ever see shamt==0 in practice,
  // but the full barrel form keeps f() correct for any caller.
  always_comb begin
    sum   = SrcA + SrcB;
    diff  = SrcA - SrcB;
    f_res = '0;
    f_ovf = 1'b0;
    case (ALU_control)
      OP_ADD: begin
        f_res = sum;
        f_ovf = (SrcA[XLEN-1] == SrcB[XLEN-1]) && (sum[XLEN-1] != SrcA[XLEN-1]);
      end
      OP_SUB: begin
        f_res = diff;
        f_ovf = (SrcA[XLEN-1] != SrcB[XLEN-1]) && (diff[XLEN-1] != SrcA[XLEN-1]);
      end
      OP_SLL:  f_res = SrcA << shamt;
      OP_SRL:  f_res = SrcA >> shamt;
      OP_XOR:  f_res = SrcA ^ SrcB;
      OP_OR:   f_res = SrcA | SrcB;
      OP_AND:  f_res = SrcA & SrcB;
      default: f_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ALU_result <= '0;
      Zero       <= 1'b1;
      Overflow   <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      shl        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift && (shamt != '0)) begin
              acc   <= SrcA;
              cnt   <= shamt;
              shl   <= (ALU_control == OP_SLL);
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              ALU_result <= f_res;
              Zero       <= (f_res == '0);
              Overflow   <= f_ovf;
              done       <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= acc_nx;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            ALU_result <= acc_nx;
            Zero       <= (acc_nx == '0);
            Overflow   <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench: driver pushes expected completions into a queue,
// a monitor pops and compares on every done pulse (value, flags, latency, busy length).
module tb_alu_exec_unit;
  logic        clk, rst_n, start;
  logic [2:0]  ALU_control;
  logic [31:0] SrcA, SrcB;
  logic        busy, done, Zero, Overflow;
  logic [31:0] ALU_result;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_control(ALU_control),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .ALU_result(ALU_result), .Zero(Zero), .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    int          cyc;
    int          n;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", ALU_result, e.res);
          chk("zero", {31'd0, Zero}, {31'd0, e.z});
          chk("overflow", {31'd0, Overflow}, {31'd0, e.o});
          chk("latency", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, e.n);
        end
        busy_cnt = 0;
      end
    end
  end

  // Drive at a negedge; accepted at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input logic o, input int n);
    exp_t e;
    ALU_control = op; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk); #1;
    e.res = r; e.z = z; e.o = o; e.cyc = cyc + n; e.n = n;
    q.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && k < 100) begin
      @(negedge clk); k++;
    end
    if (k >= 100) chk("timeout_idle", 32'd1, 32'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic z, input logic o, input int n);
    @(negedge clk);
    issue(op, a, b, r, z, o, n);
    wait_idle();
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; ALU_control = 3'b000; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", ALU_result, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd1);
    chk("rst_ovf", {31'd0, Overflow}, 32'd0);
    rst_n = 1'b1;

    // Arithmetic / logic, single-cycle
    run(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 0);
    run(3'b010, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 0);
    run(3'b010, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    run(3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 0);
    run(3'b111, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0, 0);
    run(3'b110, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1'b0, 0);
    run(3'b011, 32'd5, 32'd3, 32'h0, 1'b1, 1'b0, 0);

    // Flags hold while a shift is in flight
    run(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 0);
    @(negedge clk);
    issue(3'b001, 32'h1, 32'd5, 32'h20, 1'b0, 1'b0, 5);
    @(negedge clk);
    chk("hold_result", ALU_result, 32'h8000_0000);
    chk("hold_ovf", {31'd0, Overflow}, 32'd1);
    wait_idle();

    // Serial shifts
    run(3'b001, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 31);
    run(3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 4);
    run(3'b001, 32'hA5, 32'h20, 32'hA5, 1'b0, 1'b0, 0);
    run(3'b101, 32'hA5, 32'h21, 32'h52, 1'b0, 1'b0, 1);

    // start while busy is ignored; then back-to-back on the done cycle
    @(negedge clk);
    issue(3'b001, 32'h1, 32'd10, 32'h400, 1'b0, 1'b0, 10);
    repeat (2) @(negedge clk);
    ALU_control = 3'b000; SrcA = 32'hFFFF; SrcB = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; SrcA = 32'h1234_5678;
    k = 0;
    while (!done && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("timeout_done", 32'd1, 32'd0);
    issue(3'b010, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 0);
    wait_idle();

    // Async reset in the middle of a 10-bit shift
    @(negedge clk);
    issue(3'b001, 32'h3, 32'd10, 32'hC00, 1'b0, 1'b0, 10);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_result", ALU_result, 32'd0);
    chk("mid_rst_zero", {31'd0, Zero}, 32'd1);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_result", ALU_result, 32'd0);
    run(3'b100, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
